uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Fabric-side UART receiver that decodes the serial TX line driven by the processor subsystem's UART and delivers received bytes over a valid/ready byte interface. It sits either in the simulation bench or in fabric logic, as the far end of the subsystem's TX pin. It provides:
- 8N1 framing (optional parity);
- a 2-FF input synchroniser;
- mid-bit sampling from a programmable baud divider;
- a small show-ahead FIFO with overflow and framing-error reporting.

## Interface
Parameters:
- BAUD_DIV, 434, CLK cycles per bit (50 MHz / 115200); minimum 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd; used only when the parity macro is defined.

Ports:
- CLK  in  1  single clock for all logic.
- RESET  in  1  asynchronous, active-high reset.
- RX  in  1  serial input, connected to the subsystem TX; idle high; asynchronous to CLK.
- DATA  out  8  head-of-FIFO byte; 0x00 when the FIFO is empty.
- DATA_VALID  out  1  FIFO not empty.
- DATA_READY  in  1  consumer accepts DATA this cycle.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled 0.
- PARITY_ERR  out  1  one-cycle pulse: parity mismatch; constant 0 without the macro.
- OVERFLOW  out  1  sticky: a byte was dropped because the FIFO was full.
- ERR_CLR  in  1  synchronous clear of OVERFLOW.

## Operation
- RX passes through a 2-FF synchroniser; both flops reset to 1. All decisions use the synchronised value rx_s.
- Baud counter: loaded on state entry, decrements each cycle; "tick" = counter at 0.
- State machine:
  - IDLE: if rx_s == 0, load BAUD_DIV/2 - 1 and go to START.
  - START: on tick, if rx_s == 0, load BAUD_DIV - 1, clear bit count, go to DATA. Otherwise this is a glitch: go to IDLE with no error reported.
  - DATA: on each tick, shift rx_s into the shift register MSB (LSB-first order) and reload the counter. After 8 samples, go to PARITY if the macro is defined, else to STOP.
  - PARITY (macro only): on tick, compare rx_s with the computed parity and latch a mismatch flag; go to STOP.
  - STOP: on tick, evaluate the stop sample:
    - rx_s == 1 and no parity mismatch: push the byte; go to IDLE.
    - rx_s == 1 with a parity mismatch: pulse PARITY_ERR, drop the byte; go to IDLE.
    - rx_s == 0: pulse FRAME_ERR (plus PARITY_ERR if mismatched), drop the byte; go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s == 1, then go to IDLE. A held-low break line therefore yields exactly one FRAME_ERR.
- STOP returns to IDLE at mid-stop-bit. This allows back-to-back frames and tolerates up to roughly ±4% baud mismatch.
- FIFO behaviour:
  - Pop occurs when DATA_VALID && DATA_READY.
  - Push while full drops the byte and sets OVERFLOW.
  - Push and pop in the same cycle while full: both succeed and OVERFLOW is not set.
  - Push and pop in the same cycle while neither empty nor full: occupancy is unchanged.
- OVERFLOW clears on ERR_CLR. If ERR_CLR and a new overflow coincide, the overflow wins and OVERFLOW stays 1.

## Timing
- Reset values:
  - DATA = 0x00; DATA_VALID, FRAME_ERR, PARITY_ERR, OVERFLOW = 0.
  - State = IDLE; FIFO empty; sync flops = 1.
- RESET mid-frame aborts immediately: the partial byte is discarded and no error pulses are produced.
- Input latency: 2 CLK cycles from an RX edge to rx_s.
- Bit sampling: the start bit is sampled BAUD_DIV/2 cycles after it is detected. Each following bit is sampled BAUD_DIV cycles after the previous sample.
- Output latency: DATA_VALID rises 1 cycle after the stop-bit tick when the FIFO was empty. FRAME_ERR and PARITY_ERR assert in that same cycle.
- DATA is show-ahead: the next entry appears the cycle after a pop.
- DATA is stable while DATA_VALID = 1 and DATA_READY = 0.

## Configuration
- UART_FRAME_RX_PARITY_EN defined:
  - the PARITY state is compiled in and a parity bit is expected after bit 7;
  - parity polarity is selected by PARITY_ODD;
  - a frame is 11 bit times.
- Not defined:
  - 8N1 only (10 bit times);
  - PARITY state and mismatch logic are absent;
  - PARITY_ERR is tied to 0.
- The port list is identical in both builds.

## Structure
- Package uart_frame_rx_pkg contains:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT);
  - DATA_BITS = 8;
  - the bit-counter width constant.
- Sub-module uart_rx_fifo: a show-ahead FIFO parameterised by FIFO_DEPTH, with push/full/pop/empty ports and a wrap-around pointer plus an extra full bit.

## Test plan
All scenarios use BAUD_DIV = 16 and FIFO_DEPTH = 4.
- 0x55 then 0xA3 sent back-to-back, DATA_READY = 1 -> DATA 0x55 then 0xA3 in order; FRAME_ERR, PARITY_ERR and OVERFLOW stay 0.
- RX low for 3 cycles, then high -> no DATA_VALID, no error; the next 0x0F frame is received correctly.
- 0x7E with stop bit 0, then RX held low for 40 bit times -> exactly one FRAME_ERR pulse, no DATA_VALID. Then release RX and send 0x81 -> 0x81 received.
- DATA_READY = 0, send 0x01–0x05 -> 0x01–0x04 retained in order, 0x05 dropped, OVERFLOW = 1. Pulse ERR_CLR -> OVERFLOW = 0.
- Macro defined, PARITY_ODD = 0:
  - 0x01 with parity bit 0 -> PARITY_ERR pulse, byte dropped;
  - 0x01 with parity bit 1 -> DATA = 0x01.
- RESET asserted at data bit 4 of a frame -> all outputs return to reset values that cycle. The next 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_frame_rx_pkg.sv
// Shared types and constants for the fabric-side UART receiver.
// The parity option is selected by the UART_FRAME_RX_PARITY_EN macro.
package uart_frame_rx_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

   // ST_ prefix keeps the DATA literal clear of the DATA output port
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRK_WAIT
   } state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; pointers carry one extra wrap bit to tell full from empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   input  logic             pop,
   output logic             empty,
   output logic [WIDTH-1:0] rdata
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_frame_rx.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling FSM and show-ahead byte FIFO.
// Define UART_FRAME_RX_PARITY_EN to expect a parity bit after bit 7 (polarity from PARITY_ODD).
module uart_frame_rx
   import uart_frame_rx_pkg::*;
#(
   parameter int BAUD_DIV   = 434,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RX,
   output logic [7:0] DATA,
   output logic       DATA_VALID,
   input  logic       DATA_READY,
   output logic       FRAME_ERR,
   output logic       PARITY_ERR,
   output logic       OVERFLOW,
   input  logic       ERR_CLR
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

   state_t               state;
   state_t               state_next;
   logic                 rx_meta;
   logic                 rx_s;
   logic [CNT_W-1:0]     cnt;
   logic                 tick;
   logic                 load_half;
   logic                 load_full;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [7:0]           shreg;
   logic                 mismatch;
   logic                 push;
   logic                 ferr_set;
   logic                 perr_set;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign tick       = (cnt == '0);
   assign pop        = DATA_VALID && DATA_READY;
   assign DATA_VALID = !fifo_empty;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_half  = 1'b0;
      load_full  = 1'b0;
      case (state)
         ST_IDLE: if (!rx_s) begin
            state_next = ST_START;
            load_half  = 1'b1;
         end
         ST_START: if (tick) begin
            if (!rx_s) begin
               state_next = ST_DATA;
               load_full  = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_DATA: if (tick) begin
            load_full = 1'b1;
`ifdef UART_FRAME_RX_PARITY_EN
            if (bit_cnt == LAST_BIT) state_next = ST_PARITY;
`else
            if (bit_cnt == LAST_BIT) state_next = ST_STOP;
`endif
         end
         ST_PARITY: if (tick) begin
            load_full  = 1'b1;
            state_next = ST_STOP;
         end
         ST_STOP: if (tick) state_next = rx_s ? ST_IDLE : ST_BRK_WAIT;
         ST_BRK_WAIT: if (rx_s) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      push     = 1'b0;
      ferr_set = 1'b0;
      perr_set = 1'b0;
      if (state == ST_STOP && tick) begin
         push     = rx_s && !mismatch;
         ferr_set = !rx_s;
         perr_set = mismatch;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         FRAME_ERR <= 1'b0;
         OVERFLOW  <= 1'b0;
      end else begin
         rx_meta   <= RX;
         rx_s      <= rx_meta;
         FRAME_ERR <= ferr_set;
         if (load_half)      cnt <= HALF_LOAD;
         else if (load_full) cnt <= FULL_LOAD;
         else if (!tick)     cnt <= cnt - 1'b1;
         if (state == ST_START && tick) bit_cnt <= '0;
         else if (state == ST_DATA && tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= {rx_s, shreg[7:1]};
         end
         // a new overflow takes priority over a coincident clear
         if (push && fifo_full && !pop) OVERFLOW <= 1'b1;
         else if (ERR_CLR)              OVERFLOW <= 1'b0;
      end
   end

`ifdef UART_FRAME_RX_PARITY_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mismatch   <= 1'b0;
         PARITY_ERR <= 1'b0;
      end else begin
         PARITY_ERR <= perr_set;
         if (state == ST_START && tick) mismatch <= 1'b0;
         else if (state == ST_PARITY && tick)
            mismatch <= (rx_s != ((^shreg) ^ 1'(PARITY_ODD)));
      end
   end
`else
   assign mismatch   = 1'b0;
   assign PARITY_ERR = 1'b0;
`endif

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .push  (push),
      .wdata (shreg),
      .full  (fifo_full),
      .pop   (pop),
      .empty (fifo_empty),
      .rdata (DATA)
   );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: frames driven bit by bit, checked against a frame-level byte/error model.
// Parity scenarios are compiled in when UART_FRAME_RX_PARITY_EN is defined.
module tb_uart_frame_rx;

   localparam int BAUD  = 16;
   localparam int DEPTH = 4;
   localparam int PODD  = 0;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       RX = 1'b1;
   logic [7:0] DATA;
   logic       DATA_VALID;
   logic       DATA_READY = 1'b1;
   logic       FRAME_ERR;
   logic       PARITY_ERR;
   logic       OVERFLOW;
   logic       ERR_CLR = 1'b0;

   int total = 0;
   int bad   = 0;
   int ferr_seen = 0;
   int perr_seen = 0;
   int exp_ferr  = 0;
   int exp_perr  = 0;
   int exp_ovf   = 0;
   logic [7:0] exp_q [$];

   uart_frame_rx #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH),
      .PARITY_ODD (PODD)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .RX         (RX),
      .DATA       (DATA),
      .DATA_VALID (DATA_VALID),
      .DATA_READY (DATA_READY),
      .FRAME_ERR  (FRAME_ERR),
      .PARITY_ERR (PARITY_ERR),
      .OVERFLOW   (OVERFLOW),
      .ERR_CLR    (ERR_CLR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // consumer side: every accepted byte must be the next one the model expects
   always @(negedge CLK) begin
      if (!RESET) begin
         if (FRAME_ERR)  ferr_seen++;
         if (PARITY_ERR) perr_seen++;
         if (DATA_VALID && DATA_READY) begin
            if (exp_q.size() == 0) check("pop_with_nothing_expected", 0, 1);
            else                   check("pop_data", DATA, exp_q.pop_front());
         end
      end
   end

   task automatic drive_bit(input logic v);
      RX = v;
      repeat (BAUD) @(posedge CLK);
      #1;
   endtask

   task automatic idle_bits(input int n);
      drive_bit(1'b1);
      for (int i = 1; i < n; i++) drive_bit(1'b1);
   endtask

   // model decides the frame's fate when the stop bit starts, well before the DUT samples it
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
      logic pb;
      pb = par_bad;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_FRAME_RX_PARITY_EN
      drive_bit((^b) ^ 1'(PODD) ^ pb);
`else
      pb = 1'b0;
`endif
      if (!stop_bit) begin
         exp_ferr++;
         if (pb) exp_perr++;
      end else if (pb) begin
         exp_perr++;
      end else if (exp_q.size() == DEPTH && !DATA_READY) begin
         exp_ovf = 1;
      end else begin
         exp_q.push_back(b);
      end
      drive_bit(stop_bit);
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge CLK);
      repeat (3) @(posedge CLK);
      #1;
      check("drain_left", exp_q.size(), 0);
      check("valid_after_drain", DATA_VALID, 0);
      check("data_when_empty", DATA, 0);
   endtask

   task automatic check_errs(input string tag);
      check({tag, "_ferr"}, ferr_seen, exp_ferr);
      check({tag, "_perr"}, perr_seen, exp_perr);
      check({tag, "_ovf"}, OVERFLOW, exp_ovf);
   endtask

   initial begin
      #1 RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_data", DATA, 0);
      check("rst_valid", DATA_VALID, 0);
      check("rst_ferr", FRAME_ERR, 0);
      check("rst_perr", PARITY_ERR, 0);
      check("rst_ovf", OVERFLOW, 0);
      RESET = 1'b0;
      idle_bits(2);

      // back-to-back frames
      send_frame(8'h55, 1'b1, 1'b0);
      send_frame(8'hA3, 1'b1, 1'b0);
      idle_bits(1);
      drain(50);
      check_errs("b2b");

      // short low glitch must be ignored
      RX = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      idle_bits(2);
      check("glitch_valid", DATA_VALID, 0);
      check_errs("glitch");
      send_frame(8'h0F, 1'b1, 1'b0);
      idle_bits(1);
      drain(50);

      // bad stop bit followed by a long break: one frame error only
      send_frame(8'h7E, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) drive_bit(1'b0);
      idle_bits(2);
      check_errs("break");
      send_frame(8'h81, 1'b1, 1'b0);
      idle_bits(1);
      drain(50);

      // stalled consumer: fifth byte is dropped
      DATA_READY = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
      idle_bits(1);
      check("ovf_valid", DATA_VALID, 1);
      check("ovf_head", DATA, exp_q[0]);
      check("ovf_count", exp_q.size(), 4);
      check_errs("ovf");
      ERR_CLR = 1'b1;
      @(posedge CLK);
      #1;
      ERR_CLR = 1'b0;
      exp_ovf = 0;
      check("ovf_cleared", OVERFLOW, exp_ovf);
      check("head_held", DATA, exp_q[0]);
      DATA_READY = 1'b1;
      drain(50);

`ifdef UART_FRAME_RX_PARITY_EN
      send_frame(8'h01, 1'b1, 1'b1);
      idle_bits(1);
      check_errs("par_bad");
      send_frame(8'h01, 1'b1, 1'b0);
      idle_bits(1);
      drain(50);
      check_errs("par_good");
`endif

      // randomized frames, stop errors, consumer stalls and gaps
      for (int n = 0; n < 24; n++) begin
         logic [7:0] b;
         logic stop_ok;
         logic pbad;
         b = 8'($urandom_range(0, 255));
         stop_ok = ($urandom_range(0, 5) != 0);
         pbad = ($urandom_range(0, 4) == 0);
         DATA_READY = ($urandom_range(0, 3) != 0);
         send_frame(b, stop_ok, pbad);
         if (!stop_ok) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) drive_bit(1'b0);
            idle_bits(1);
         end
         RX = 1'b1;
         repeat ($urandom_range(0, 20)) @(posedge CLK);
         #1;
      end
      DATA_READY = 1'b1;
      idle_bits(1);
      drain(100);
      check_errs("random");

      // reset in the middle of a frame with a byte still held
      DATA_READY = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b0);
      idle_bits(1);
      check("pre_rst_valid", DATA_VALID, 1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0]);
      RX = 1'b0;
      repeat (BAUD / 2) @(posedge CLK);
      #1;
      RESET = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_valid", DATA_VALID, 0);
      check("mid_rst_data", DATA, 0);
      check("mid_rst_ferr", FRAME_ERR, 0);
      check("mid_rst_perr", PARITY_ERR, 0);
      check("mid_rst_ovf", OVERFLOW, 0);
      RX = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      DATA_READY = 1'b1;
      idle_bits(2);
      send_frame(8'hC3, 1'b1, 1'b0);
      idle_bits(1);
      drain(50);
      check_errs("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
